// File: rtl/flag_write_arbiter.sv
// -----------------------------------------------------------------------------
// flag_write_arbiter
//
// Shares the single write port of the flag register among NREQ producers
// (ALU, compare, flag-move). One producer is granted per cycle in round-robin
// order. Its masked flag bits are merged over the current flag value and
// driven to the flag register's data/write pins.
//
// Optional feature macro: FLAGARB_SCOREBOARD_EN
//   When defined, a pending-reservation counter drives busy_o so that flag
//   readers stall until every reserved update has landed. It also drives a
//   sticky over/underflow flag on err_o. When undefined, reserve_i is ignored
//   and busy_o/err_o are tied low.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   FW       flag width, matches the flag register
//   MAXPEND  max outstanding reservations tracked (scoreboard only)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   req_i        per-requester update request, held until granted
//   flags_i      requester k new flags at [k*FW +: FW]
//   mask_i       requester k bit-enable at [k*FW +: FW]
//   gnt_o        one-hot grant, registered, high one cycle per grant
//   cur_flags_i  flag register data_o
//   data_o       to flag register data_i
//   write_o      to flag register write
//   reserve_i    issue stage reserves one future flag write
//   busy_o       pending reservations != 0 (registered)
//   err_o        sticky scoreboard over/underflow
// -----------------------------------------------------------------------------
module flag_write_arbiter #(
    parameter int NREQ    = 3,
    parameter int FW      = 6,
    parameter int MAXPEND = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*FW-1:0]   flags_i,
    input  logic [NREQ*FW-1:0]   mask_i,
    output logic [NREQ-1:0]      gnt_o,
    input  logic [FW-1:0]        cur_flags_i,
    output logic [FW-1:0]        data_o,
    output logic                 write_o,
    input  logic                 reserve_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_next;
    logic [NREQ-1:0]     elig;
    logic [2*NREQ-1:0]   elig_rot;
    logic                win_valid;
    logic [PW-1:0]       win_idx;
    logic [PW:0]         win_sum;
    logic [PW:0]         ptr_sum;
    logic [NREQ-1:0]     gnt_next;
    logic [FW-1:0]       sel_flags;
    logic [FW-1:0]       sel_mask;
    logic [FW-1:0]       base;
    logic [FW-1:0]       merged;

    // Round-robin pick. A requester granted last cycle is masked out so it
    // has a cycle to drop req_i. The doubled eligibility vector is rotated
    // down by ptr, so the first set bit of the low NREQ bits is the winner
    // offset from ptr.
    always_comb begin
        elig      = req_i & ~gnt_o;
        elig_rot  = {elig, elig} >> ptr;
        win_valid = 1'b0;
        win_idx   = '0;
        win_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_valid && elig_rot[i]) begin
                win_valid = 1'b1;
                win_sum   = {1'b0, ptr} + (PW+1)'(i);
                if (win_sum >= (PW+1)'(NREQ)) begin
                    win_sum = win_sum - (PW+1)'(NREQ);
                end
                win_idx = win_sum[PW-1:0];
            end
        end

        ptr_sum = {1'b0, win_idx} + (PW+1)'(1);
        if (ptr_sum >= (PW+1)'(NREQ)) begin
            ptr_sum = '0;
        end
        ptr_next = ptr_sum[PW-1:0];

        gnt_next = win_valid ? (NREQ'(1) << win_idx) : '0;
    end

    // Merge the winner's masked bits. When a write is already in flight,
    // the flag register has not captured it yet. So the merge base is our
    // own data_o, which keeps back-to-back partial updates from reading
    // stale flags.
    always_comb begin
        sel_flags = '0;
        sel_mask  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_next[k]) begin
                sel_flags = flags_i[k*FW +: FW];
                sel_mask  = mask_i[k*FW +: FW];
            end
        end
        base   = write_o ? data_o : cur_flags_i;
        merged = (base & ~sel_mask) | (sel_flags & sel_mask);
    end

    // Grant/write registers. data_o and ptr hold through idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_o   <= '0;
            write_o <= 1'b0;
            data_o  <= '0;
            ptr     <= '0;
        end else begin
            gnt_o   <= gnt_next;
            write_o <= win_valid;
            if (win_valid) begin
                data_o <= merged;
                ptr    <= ptr_next;
            end
        end
    end

`ifdef FLAGARB_SCOREBOARD_EN
    localparam int PENDW = $clog2(MAXPEND + 1);

    logic [PENDW-1:0] pend;
    logic [PENDW-1:0] pend_next;
    logic             err_next;

    // A grant issued on this edge retires one reservation, and reserve_i adds
    // one. When both happen on the same edge they cancel. Saturation at
    // either end holds the count and sets the sticky error.
    always_comb begin
        pend_next = pend;
        err_next  = err_o;
        if (reserve_i && !win_valid) begin
            if (pend == PENDW'(MAXPEND)) begin
                err_next = 1'b1;
            end else begin
                pend_next = pend + PENDW'(1);
            end
        end else if (win_valid && !reserve_i) begin
            if (pend == '0) begin
                err_next = 1'b1;
            end else begin
                pend_next = pend - PENDW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend   <= '0;
            busy_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            pend   <= pend_next;
            busy_o <= (pend_next != '0);
            err_o  <= err_next;
        end
    end
`else
    logic unused_reserve;

    assign unused_reserve = reserve_i;
    assign busy_o         = 1'b0;
    assign err_o          = 1'b0;
`endif

endmodule
